// File: rtl/board_mem_arbiter_if.sv
// Board RAM access bundle: display port, cpu port, RAM port and the
// blanking flag from the VGA timing chain. The arbiter connects through
// the slave modport. The requesters and the RAM model connect through
// the master modport.
interface board_mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
);
  logic              vga_blank_n;
  // display (pixel renderer) port
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  // cpu (game-logic engine) port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_starved;
  // single-port board RAM
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  vga_blank_n,
    input  disp_req, disp_addr,
    output disp_rvalid, disp_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_starved,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // requester / RAM side
  modport master (
    output vga_blank_n,
    output disp_req, disp_addr,
    input  disp_rvalid, disp_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_starved,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// Chess-board RAM arbiter. The display port reads from the board RAM every
// cycle it asks and always gets the RAM first. The cpu port uses the idle
// slots, so blanking always gives it a slot. Every issued access carries an
// owner tag down a pipe that matches the RAM read latency. The tag steers
// the returned data back to the port that asked for it.
//
// Optional build macro WRITE_BLANK_ONLY_EN: when it is defined, cpu writes
// are granted only while vga_blank_n=0, so the board never changes in the
// middle of a frame. cpu reads are not affected.
module board_mem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 4,
  parameter int RD_LATENCY = 1,
  parameter int MAX_STALL  = 800
) (
  input  logic               vga_clk,
  input  logic               reset,
  board_mem_arbiter_if.slave bus
);

  localparam int               CNT_W     = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] STALL_SAT = CNT_W'(MAX_STALL);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } cpu_state_t;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_CPU  = 1'b1
  } owner_t;

  cpu_state_t       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_cnt_nxt;
  logic             starved_q;

  logic             wr_ok;
  logic             cpu_grant;
  owner_t           issue_own;

  // Tag pipe. Stage 0 holds the access issued last cycle. Stage
  // RD_LATENCY-1 lines up with mem_rdata.
  logic             vld_p [RD_LATENCY];
  owner_t           own_p [RD_LATENCY];
  logic             wr_p  [RD_LATENCY];

  logic             vld_out;
  owner_t           own_out;
  logic             wr_out;
  logic             disp_hit;
  logic             cpu_hit;

  // Wait counter that stops at MAX_STALL.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == STALL_SAT) ? v : v + CNT_W'(1);
  endfunction

`ifdef WRITE_BLANK_ONLY_EN
  // Board writes wait for blanking. Reads may go in any idle slot.
  assign wr_ok = !bus.cpu_we || !bus.vga_blank_n;
`else
  // Without the blanking restriction the blanking flag is not needed.
  logic unused_blank;
  assign unused_blank = bus.vga_blank_n;
  assign wr_ok        = 1'b1;
`endif

  // The cpu gets the RAM only in a slot the display left free, and never
  // while an earlier cpu access is still in flight.
  assign cpu_grant = !reset && (state == IDLE) && bus.cpu_req &&
                     !bus.disp_req && wr_ok;

  // Drive the RAM port: display first, then a granted cpu access.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    issue_own     = OWN_DISP;
    if (!reset && bus.disp_req) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.disp_addr;
    end else if (cpu_grant) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      issue_own     = OWN_CPU;
    end
  end

  // Next wait count: it counts blocked cycles in IDLE, it clears when the
  // request is granted or dropped, and it holds while in WAIT.
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (!bus.cpu_req || cpu_grant) begin
      stall_cnt_nxt = '0;
    end else if (state == IDLE) begin
      stall_cnt_nxt = sat_inc(stall_cnt);
    end
  end

  // cpu FSM, wait counter and registered starvation flag.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
      starved_q <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      starved_q <= (stall_cnt_nxt == STALL_SAT);
      case (state)
        IDLE:    if (cpu_grant) state <= WAIT;
        WAIT:    if (cpu_hit)   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- issue -> tag stage 0 ... RD_LATENCY-1 ----
  // Valid bits of the tag pipe. Reset drops every in-flight access.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= bus.mem_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Owner and write bits of the tag pipe. They are read only when the
  // matching valid bit is set.
  always_ff @(posedge vga_clk) begin
    own_p[0] <= issue_own;
    wr_p[0]  <= bus.mem_we;
    for (int i = 1; i < RD_LATENCY; i++) begin
      own_p[i] <= own_p[i-1];
      wr_p[i]  <= wr_p[i-1];
    end
  end

  // ---- tag output stage -> requester ports ----
  assign vld_out  = vld_p[RD_LATENCY-1];
  assign own_out  = own_p[RD_LATENCY-1];
  assign wr_out   = wr_p[RD_LATENCY-1];
  assign disp_hit = vld_out && (own_out == OWN_DISP);
  assign cpu_hit  = vld_out && (own_out == OWN_CPU);

  assign bus.disp_rvalid = disp_hit;
  assign bus.disp_rdata  = disp_hit ? bus.mem_rdata : '0;
  assign bus.cpu_ack     = cpu_hit;
  // A write completion returns zero so that stale RAM output never reaches the cpu.
  assign bus.cpu_rdata   = (cpu_hit && !wr_out) ? bus.mem_rdata : '0;
  assign bus.cpu_starved = starved_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter with a behavioural board RAM (latency 3) and
// scoreboards for the display and cpu ports.
`timescale 1ns/1ps
module tb_board_mem_arbiter;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 4;
  localparam int RD_LAT    = 3;
  localparam int MAX_STALL = 8;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [DATA_W-1:0] golden  [64];
  logic [DATA_W-1:0] ram     [64];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  exp_t disp_q [$];
  exp_t cpu_q  [$];

  always #20 vga_clk = ~vga_clk;

  board_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  board_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .MAX_STALL(MAX_STALL)
  ) dut (
    .vga_clk(vga_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always @(posedge vga_clk) cyc <= cyc + 1;

  // Behavioural board RAM with RD_LAT cycles of read latency. It takes its
  // contents from golden at the first edge. Slots with no access return
  // random data.
  always @(posedge vga_clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) ram[i] <= golden[i];
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    rd_pipe[0] <= bus.mem_en ? ram[bus.mem_addr] : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Scoreboards: each cycle a port must either deliver the entry due now or stay quiet.
  always @(negedge vga_clk) begin
    if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
      chk("disp_rvalid", 32'(bus.disp_rvalid), 1);
      chk("disp_rdata", 32'(bus.disp_rdata), 32'(disp_q[0].data));
      void'(disp_q.pop_front());
    end else begin
      chk("disp_rvalid_idle", 32'(bus.disp_rvalid), 0);
    end
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      chk("cpu_ack", 32'(bus.cpu_ack), 1);
      chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_q[0].data));
      void'(cpu_q.pop_front());
    end else begin
      chk("cpu_ack_idle", 32'(bus.cpu_ack), 0);
    end
  end

  function automatic logic [31:0] all_outputs();
    return 32'({bus.disp_rvalid, bus.disp_rdata, bus.cpu_ack, bus.cpu_rdata,
                bus.cpu_starved, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata});
  endfunction

  task automatic disp_read(input logic [ADDR_W-1:0] addr);
    exp_t e;
    e.due  = cyc + RD_LAT;
    e.data = golden[addr];
    disp_q.push_back(e);
    bus.disp_req  = 1'b1;
    bus.disp_addr = addr;
  endtask

  task automatic hold_cpu_until(input int due);
    while (cyc <= due) tick();
    bus.cpu_req = 1'b0;
  endtask

  // Starts a cpu access in the current cycle. The caller passes how many
  // cycles the grant should be delayed. The task holds cpu_req until the ack cycle has passed.
  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input int gdelay);
    exp_t e;
    e.due  = cyc + gdelay + RD_LAT;
    e.data = we ? '0 : golden[addr];
    cpu_q.push_back(e);
    if (we) golden[addr] = wdata;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    hold_cpu_until(e.due);
  endtask

  initial begin
    int   c0;
    int   blank_hold;
    exp_t e;
    bus.vga_blank_n = 1'b1;
    bus.disp_req    = 1'b0;
    bus.disp_addr   = '0;
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = '0;
    for (int i = 0; i < 64; i++) golden[i] = DATA_W'(i * 7 + 3);
    golden[5] = 4'hA;

    // Reset held with random inputs: every output must be zero.
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.vga_blank_n = 1'($urandom);
      bus.disp_req    = 1'($urandom);
      bus.disp_addr   = ADDR_W'($urandom);
      bus.cpu_req     = 1'($urandom);
      bus.cpu_we      = 1'($urandom);
      bus.cpu_addr    = ADDR_W'($urandom);
      bus.cpu_wdata   = DATA_W'($urandom);
      @(negedge vga_clk);
      chk("reset_outputs", all_outputs(), 0);
    end
    tick();
    bus.vga_blank_n = 1'b1;
    bus.disp_req    = 1'b0;
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    reset           = 1'b0;
    tick();
    tick();

    // A single display read of square 5, then a burst of back-to-back reads.
    disp_read(6'd5);
    tick();
    bus.disp_req = 1'b0;
    repeat (4) tick();
    for (int a = 0; a < 16; a++) begin
      disp_read(ADDR_W'(a * 3 + 1));
      tick();
    end
    bus.disp_req = 1'b0;
    repeat (5) tick();

    // Collision: the display wins, the cpu read goes in the next slot, and a
    // display read during WAIT returns in order.
    fork
      cpu_access(1'b0, 6'd10, 4'h0, 1);
      begin
        disp_read(6'd20);
        @(negedge vga_clk);
        chk("collide_mem_addr", 32'(bus.mem_addr), 20);
        chk("collide_mem_we", 32'(bus.mem_we), 0);
        tick();
        bus.disp_req = 1'b0;
        @(negedge vga_clk);
        chk("cpu_grant_mem_addr", 32'(bus.mem_addr), 10);
        tick();
        disp_read(6'd21);
        tick();
        bus.disp_req = 1'b0;
      end
    join
    repeat (4) tick();

    // cpu write then read of square 63, issued during blanking.
    bus.vga_blank_n = 1'b0;
    cpu_access(1'b1, 6'd63, 4'h7, 0);
    cpu_access(1'b0, 6'd63, 4'h0, 0);
    bus.vga_blank_n = 1'b1;
    repeat (3) tick();

    // Starvation: the display holds the RAM for 12 cycles.
    c0            = cyc;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 6'd33;
    e.due         = c0 + 12 + RD_LAT;
    e.data        = golden[33];
    cpu_q.push_back(e);
    for (int k = 1; k <= 12; k++) begin
      disp_read(ADDR_W'(k + 40));
      @(negedge vga_clk);
      chk("cpu_starved", 32'(bus.cpu_starved), 32'(k >= 9));
      tick();
    end
    bus.disp_req = 1'b0;
    @(negedge vga_clk);
    chk("starved_at_grant", 32'(bus.cpu_starved), 1);
    chk("starve_grant_mem_addr", 32'(bus.mem_addr), 33);
    tick();
    @(negedge vga_clk);
    chk("starved_after_grant", 32'(bus.cpu_starved), 0);
    hold_cpu_until(c0 + 12 + RD_LAT);
    repeat (3) tick();

    // Reset one cycle after a cpu grant: the access is dropped, and the request
    // that is still held completes after reset is released.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 6'd12;
    @(negedge vga_clk);
    chk("midop_grant_mem_en", 32'(bus.mem_en), 1);
    tick();
    reset = 1'b1;
    @(negedge vga_clk);
    chk("midop_reset_outputs", all_outputs(), 0);
    tick();
    @(negedge vga_clk);
    chk("midop_reset_outputs2", all_outputs(), 0);
    tick();
    reset  = 1'b0;
    e.due  = cyc + RD_LAT;
    e.data = golden[12];
    cpu_q.push_back(e);
    @(negedge vga_clk);
    chk("regrant_mem_en", 32'(bus.mem_en), 1);
    hold_cpu_until(e.due);
    repeat (3) tick();

    // cpu write during active video, then a read back during active video.
`ifdef WRITE_BLANK_ONLY_EN
    blank_hold = 6;
`else
    blank_hold = 0;
`endif
    bus.vga_blank_n = 1'b1;
    fork
      cpu_access(1'b1, 6'd40, 4'hC, blank_hold);
      begin
        for (int k = 0; k < blank_hold; k++) begin
          @(negedge vga_clk);
          chk("active_video_mem_we", 32'(bus.mem_we), 0);
          tick();
        end
        bus.vga_blank_n = 1'b0;
        @(negedge vga_clk);
        chk("write_grant_mem_we", 32'(bus.mem_we), 1);
        tick();
        bus.vga_blank_n = 1'b1;
      end
    join
    cpu_access(1'b0, 6'd40, 4'h0, 0);

    repeat (6) tick();
    chk("disp_q_drained", 32'(disp_q.size()), 0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
